mem_arbiter: RTL and testbench

Two-port arbiter that shares the single 64x8 data memory between the CPU (requester 0) and an external loader/debug port (requester 1). It sits between both requesters and the memory's address/writedata/memWr/readdata pins, serialises accesses through a small FSM and returns read data with a fixed latency. Selection is round-robin or fixed-priority, chosen at compile time.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/loader requesters, the arbiter and the 64x8 data memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] address;
  logic          memWr;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, readdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy, address, memWr, writedata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, readdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy, address, memWr, writedata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the 64x8 data memory between CPU (0) and loader (1).
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
//
// state  | meaning
// IDLE   | waiting; samples req0/req1 and latches the winner's request
// ACCESS | memory cycle for the latched request, grant pulse to the winner
// RDWAIT | read data returned from memory, rvalid pulse to the winner
module mem_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          idx_q, idx_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          any_req;
  logic          pick;

`ifdef MEM_ARB_RR_EN
  logic last_served_q, last_served_d;

  // On a tie, the requester that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req1 && !bus.req0)
      pick = 1'b1;
    else if (bus.req1 && bus.req0)
      pick = ~last_served_q;
  end

  always_comb begin
    last_served_d = last_served_q;
    if (state_q == ST_IDLE && any_req)
      last_served_d = pick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_served_q <= 1'b1;
    else
      last_served_q <= last_served_d;
  end
`else
  always_comb begin
    pick = bus.req1 & ~bus.req0;
  end
`endif

  assign any_req = bus.req0 | bus.req1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          idx_d   = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = we_q ? ST_IDLE : ST_RDWAIT;
      end
      ST_RDWAIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs depend only on state and latched registers, never on the live requests.
  always_comb begin
    bus.gnt0      = (state_q == ST_ACCESS) && !idx_q;
    bus.gnt1      = (state_q == ST_ACCESS) &&  idx_q;
    bus.rvalid0   = (state_q == ST_RDWAIT) && !idx_q;
    bus.rvalid1   = (state_q == ST_RDWAIT) &&  idx_q;
    bus.busy      = (state_q != ST_IDLE);
    bus.memWr     = (state_q == ST_ACCESS) && we_q;
    bus.address   = addr_q;
    bus.writedata = wdata_q;
    bus.rdata     = (state_q == ST_RDWAIT) ? bus.readdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized traffic
// checked against a transaction-level model (arbitration rule + memory array).
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DW-1:0] mem   [64];
  logic [DW-1:0] m_mem [64];
  int            m_last;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory behind the arbiter.
  always @(posedge clk) begin
    if (bus.memWr) mem[bus.address] <= bus.writedata;
    bus.readdata <= mem[bus.address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef MEM_ARB_RR_EN
    return (m_last == 1) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input int w, input bit r, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (w == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One access by requester w, starting in IDLE with its request already driven.
  task automatic serve(input int w, input bit drop);
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    we = (w == 0) ? bus.we0 : bus.we1;
    a  = (w == 0) ? bus.addr0 : bus.addr1;
    d  = (w == 0) ? bus.wdata0 : bus.wdata1;
    @(posedge clk); #1;
    check("gnt0", bus.gnt0, w == 0);
    check("gnt1", bus.gnt1, w == 1);
    check("acc_memWr", bus.memWr, we);
    check("acc_address", bus.address, a);
    check("acc_busy", bus.busy, 1);
    if (we) check("acc_writedata", bus.writedata, d);
    m_last = w;
    if (we) m_mem[a] = d;
    if (drop) drive(w, 1'b0, we, a, d);
    if (!we) begin
      @(posedge clk); #1;
      check("rvalid0", bus.rvalid0, w == 0);
      check("rvalid1", bus.rvalid1, w == 1);
      check("rdata", bus.rdata, m_mem[a]);
      check("rd_gnt", {bus.gnt0, bus.gnt1}, 0);
      check("rd_memWr", bus.memWr, 0);
    end
    @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);
    check("idle_pulses", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.memWr}, 0);
    check("idle_address_hold", bus.address, a);
  endtask

  initial begin
    int w;
    checks = 0;
    errors = 0;
    m_last = 1;
    for (int i = 0; i < 64; i++) begin
      mem[i]   = DW'($urandom);
      m_mem[i] = mem[i];
    end
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    #3;
    check("rst_pulses", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.memWr, bus.busy}, 0);
    check("rst_address", bus.address, 0);
    check("rst_writedata", bus.writedata, 0);
    check("rst_rdata", bus.rdata, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // Continuous tie, all reads.
    drive(0, 1'b1, 1'b0, 6'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 6'h02, 8'h00);
    for (int k = 0; k < 6; k++) begin
      w = pick(1'b1, 1'b1);
`ifdef MEM_ARB_RR_EN
      check("tie_order", w, k % 2);
`else
      check("tie_order", w, 0);
`endif
      serve(w, 1'b0);
    end
    drive(0, 1'b0, 1'b0, 6'h01, 8'h00);
    drive(1, 1'b0, 1'b0, 6'h02, 8'h00);
    @(posedge clk); #1;

    // Single write by loader, then single read by CPU of the same location.
    drive(1, 1'b1, 1'b1, 6'h05, 8'hA5);
    serve(1, 1'b1);
    drive(0, 1'b1, 1'b0, 6'h05, 8'h00);
    serve(0, 1'b1);
    check("read_back_05", m_mem[5], 8'hA5);

    // Loader request raised during the CPU's RDWAIT cycle is ignored until IDLE.
    drive(0, 1'b1, 1'b0, 6'h07, 8'h00);
    @(posedge clk); #1;
    check("late_gnt0", bus.gnt0, 1);
    m_last = 0;
    drive(0, 1'b0, 1'b0, 6'h07, 8'h00);
    @(posedge clk); #1;
    check("late_rvalid0", bus.rvalid0, 1);
    check("late_rdata", bus.rdata, m_mem[7]);
    drive(1, 1'b1, 1'b0, 6'h09, 8'h00);
    @(posedge clk); #1;
    check("late_ignored_gnt1", bus.gnt1, 0);
    check("late_ignored_busy", bus.busy, 0);
    @(posedge clk); #1;
    check("late_gnt1", bus.gnt1, 1);
    check("late_address", bus.address, 6'h09);
    m_last = 1;
    drive(1, 1'b0, 1'b0, 6'h09, 8'h00);
    @(posedge clk); #1;
    check("late_rvalid1", bus.rvalid1, 1);
    check("late_rdata1", bus.rdata, m_mem[9]);
    @(posedge clk); #1;

    // Randomized traffic, each round issued from IDLE.
    for (int k = 0; k < 40; k++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      drive(0, r0, 1'($urandom), AW'($urandom), DW'($urandom));
      drive(1, r1, 1'($urandom), AW'($urandom), DW'($urandom));
      w = pick(r0, r1);
      serve(w, 1'b1);
      if (r0 && r1) serve(1 - w, 1'b1);
    end

    // Reset during the ACCESS cycle of a write to 6'h10.
    drive(1, 1'b1, 1'b1, 6'h10, ~m_mem[16]);
    @(posedge clk); #1;
    check("rstw_memWr_before", bus.memWr, 1);
    drive(1, 1'b0, 1'b1, 6'h10, ~m_mem[16]);
    #2 reset = 1'b0;
    #1;
    check("rstw_memWr", bus.memWr, 0);
    check("rstw_pulses", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy}, 0);
    check("rstw_address", bus.address, 0);
    check("rstw_writedata", bus.writedata, 0);
    check("rstw_rdata", bus.rdata, 0);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    m_last = 1;
    check("rstw_mem10", mem[16], m_mem[16]);
    @(negedge clk);
    check("rstw_idle", bus.busy, 0);

    // First tie after reset goes to requester 0.
    drive(0, 1'b1, 1'b0, 6'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 6'h11, 8'h00);
    w = pick(1'b1, 1'b1);
    check("post_rst_tie", w, 0);
    serve(w, 1'b1);
    serve(1 - w, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
